// File: rtl/difftest_pkg.sv
// Shared types for the difftest commit-trace buffer: halt codes, halt FSM
// states and the per-instruction trace entry.
package difftest_pkg;

  typedef enum logic [1:0] {
    HC_NONE    = 2'd0,
    HC_GOOD    = 2'd1,
    HC_BAD     = 2'd2,
    HC_TIMEOUT = 2'd3
  } halt_code_e;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } halt_state_e;

  // pc is held at full 64 bits; narrower XLEN builds truncate at the output
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        flush;
    logic [63:0] seq;
  } trace_entry_t;

endpackage

// File: rtl/difftest_mwsr_fifo.sv
// Multi-write, single-read FIFO: enabled write lanes are compacted in lane
// order into consecutive slots; one entry is read from the head per cycle.
module difftest_mwsr_fifo #(
  parameter int  NR_WR   = 2,
  parameter int  DEPTH   = 16,
  parameter type entry_t = logic [7:0]
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic   [NR_WR-1:0]          wr_en,
  input  entry_t [NR_WR-1:0]          wr_data,
  input  logic                        rd_en,
  output entry_t                      rd_data,
  output logic                        empty,
  output logic   [$clog2(DEPTH):0]    count,
  output logic   [$clog2(DEPTH):0]    free
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [CW-1:0] wptr, rptr, nwr;
  logic [AW-1:0] slot [NR_WR];

  // Each enabled lane lands at wptr + (number of enabled lanes below it)
  always_comb begin
    nwr = '0;
    for (int i = 0; i < NR_WR; i++) begin
      slot[i] = wptr[AW-1:0] + nwr[AW-1:0];
      nwr     = nwr + CW'(wr_en[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NR_WR; i++)
      if (wr_en[i]) mem[slot[i]] <= wr_data[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + nwr;
      if (rd_en && !empty) rptr <= rptr + CW'(1);
    end
  end

  assign count   = wptr - rptr;
  assign free    = CW'(DEPTH) - count;
  assign empty   = (count == '0);
  assign rd_data = mem[rptr[AW-1:0]];

endmodule

// File: rtl/difftest_commit_queue.sv
// Commit-trace buffer between the core commit stage and the difftest drain,
// with ebreak/timeout halt detection and cycle/instret counters.
module difftest_commit_queue
  import difftest_pkg::*;
#(
  parameter int NR_COMMIT = 2,
  parameter int XLEN      = 64,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NR_COMMIT-1:0]      cmt_valid,
  input  logic [NR_COMMIT*XLEN-1:0] cmt_pc,
  input  logic [NR_COMMIT*32-1:0]   cmt_inst,
  input  logic [NR_COMMIT-1:0]      cmt_break,
  input  logic [NR_COMMIT-1:0]      cmt_flush,
  input  logic [XLEN-1:0]           a0_value,
  output logic                      cmt_stall,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [XLEN-1:0]           trace_pc,
  output logic [31:0]               trace_inst,
  output logic                      trace_flush,
  output logic [63:0]               trace_seq,
  output logic                      halt,
  output logic [1:0]                halt_code,
  output logic [XLEN-1:0]           halt_a0,
  output logic [63:0]               cycle_cnt,
  output logic [63:0]               instret_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(TIMEOUT) + 1;

  halt_state_e                  state, state_nx;
  halt_code_e                   code_q;
  logic [NR_COMMIT-1:0]         acc;
  logic                         blocked, brk_acc, deq, timeout_hit, empty;
  logic [63:0]                  nacc;
  trace_entry_t [NR_COMMIT-1:0] wdata;
  trace_entry_t                 head;
  logic [CW-1:0]                count, free;
  logic [IW-1:0]                idle;

  assign cmt_stall = (free < CW'(NR_COMMIT)) | (state != ST_RUN);

  // Lanes behind the first valid break are dropped; seq follows acceptance rank
  always_comb begin
    acc     = '0;
    wdata   = '0;
    nacc    = '0;
    blocked = 1'b0;
    for (int i = 0; i < NR_COMMIT; i++) begin
      acc[i]        = cmt_valid[i] & ~blocked & ~cmt_stall;
      wdata[i].pc   = 64'(cmt_pc[i*XLEN +: XLEN]);
      wdata[i].inst = cmt_inst[i*32 +: 32];
      wdata[i].flush = cmt_flush[i];
      wdata[i].seq  = instret_cnt + nacc;
      nacc          = nacc + 64'(acc[i]);
      blocked       = blocked | (cmt_valid[i] & cmt_break[i]);
    end
  end

  assign brk_acc = |(acc & cmt_break);

  difftest_mwsr_fifo #(
    .NR_WR   (NR_COMMIT),
    .DEPTH   (DEPTH),
    .entry_t (trace_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (acc),
    .wr_data (wdata),
    .rd_en   (deq),
    .rd_data (head),
    .empty   (empty),
    .count   (count),
    .free    (free)
  );

  assign trace_valid = ~empty;
  assign deq         = trace_valid & trace_ready;
  assign trace_pc    = trace_valid ? head.pc[XLEN-1:0] : '0;
  assign trace_inst  = trace_valid ? head.inst : '0;
  assign trace_flush = trace_valid & head.flush;
  assign trace_seq   = trace_valid ? head.seq : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (brk_acc) begin
          state_nx = ST_HALT_PEND;
        end else if (acc == '0 && idle == IW'(TIMEOUT - 1)) begin
          state_nx    = ST_HALTED;
          timeout_hit = 1'b1;
        end
      end
      // nothing enqueues while pending, so this is "last entry leaves now"
      ST_HALT_PEND: if (count == CW'(deq)) state_nx = ST_HALTED;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      idle        <= '0;
      halt_a0     <= '0;
      code_q      <= HC_NONE;
    end else begin
      if (state != ST_HALTED) cycle_cnt <= cycle_cnt + 64'd1;
      instret_cnt <= instret_cnt + nacc;
      if (state == ST_RUN) begin
        if (acc != '0)                       idle <= '0;
        else if (idle != IW'(TIMEOUT - 1))   idle <= idle + IW'(1);
      end
      if (brk_acc) halt_a0 <= a0_value;
      if (state != ST_HALTED && state_nx == ST_HALTED)
        code_q <= timeout_hit ? HC_TIMEOUT : ((halt_a0 == '0) ? HC_GOOD : HC_BAD);
    end
  end

  assign halt      = (state == ST_HALTED);
  assign halt_code = code_q;

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Scoreboard bench for difftest_commit_queue: a behavioural model predicts
// accepted commits, trace beats, stall, halt and counters cycle by cycle.
module tb_difftest_commit_queue;

  localparam int NR = 2;
  localparam int XL = 64;
  localparam int DP = 16;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  cmt_valid = '0, cmt_break = '0, cmt_flush = '0;
  logic [NR*XL-1:0] cmt_pc = '0;
  logic [NR*32-1:0] cmt_inst = '0;
  logic [XL-1:0]  a0_value = '0;
  logic           trace_ready = 1'b0;
  logic           cmt_stall, trace_valid, trace_flush, halt;
  logic [XL-1:0]  trace_pc, halt_a0;
  logic [31:0]    trace_inst;
  logic [63:0]    trace_seq, cycle_cnt, instret_cnt;
  logic [1:0]     halt_code;

  always #5 clk = ~clk;

  difftest_commit_queue #(.NR_COMMIT(NR), .XLEN(XL), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .cmt_inst(cmt_inst), .cmt_break(cmt_break), .cmt_flush(cmt_flush),
    .a0_value(a0_value), .cmt_stall(cmt_stall), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_pc(trace_pc), .trace_inst(trace_inst),
    .trace_flush(trace_flush), .trace_seq(trace_seq), .halt(halt),
    .halt_code(halt_code), .halt_a0(halt_a0), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        flush;
    logic [63:0] seq;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0, n_err = 0;
  int          mstate = 0;  // 0 run, 1 halt pending, 2 halted
  int          midle = 0;
  logic [63:0] mcycle = '0, minstret = '0, ma0 = '0;
  logic [1:0]  mcode = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] b,
                       input logic [63:0] p0, input logic [63:0] p1);
    cmt_valid = v;
    cmt_break = b;
    cmt_pc    = {p1, p0};
    cmt_inst  = {p1[31:0] + 32'h13, p0[31:0] + 32'h13};
    cmt_flush = {p1[3], p0[3]};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 64'd0, 64'd0);
    trace_ready = 1'b0;
    a0_value = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    mstate = 0; midle = 0; mcycle = '0; minstret = '0; ma0 = '0; mcode = '0;
  endtask

  task automatic chk_reset();
    chk("rst_trace_valid", trace_valid, 0);
    chk("rst_trace_pc", trace_pc, 0);
    chk("rst_trace_inst", trace_inst, 0);
    chk("rst_trace_flush", trace_flush, 0);
    chk("rst_trace_seq", trace_seq, 0);
    chk("rst_halt", halt, 0);
    chk("rst_halt_code", halt_code, 0);
    chk("rst_halt_a0", halt_a0, 0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);
    chk("rst_stall", cmt_stall, 0);
  endtask

  // One clock: check DUT against the model at negedge, then advance the model
  task automatic step();
    int   cnt, nacc;
    bit   stall, blocked, brk;
    exp_t e;
    @(negedge clk);
    cnt   = exp_q.size();
    stall = ((DP - cnt) < NR) || (mstate != 0);
    chk("cmt_stall", cmt_stall, stall);
    chk("trace_valid", trace_valid, cnt != 0);
    chk("halt", halt, mstate == 2);
    chk("halt_code", halt_code, mcode);
    chk("halt_a0", halt_a0, ma0);
    chk("cycle_cnt", cycle_cnt, mcycle);
    chk("instret_cnt", instret_cnt, minstret);
    if (cnt != 0 && trace_ready) begin
      e = exp_q.pop_front();
      chk("beat_pc", trace_pc, e.pc);
      chk("beat_inst", trace_inst, e.inst);
      chk("beat_flush", trace_flush, e.flush);
      chk("beat_seq", trace_seq, e.seq);
    end
    nacc = 0; brk = 0; blocked = 0;
    if (!stall) begin
      for (int l = 0; l < NR; l++) begin
        if (cmt_valid[l] && !blocked) begin
          e.pc    = cmt_pc[l*XL +: XL];
          e.inst  = cmt_inst[l*32 +: 32];
          e.flush = cmt_flush[l];
          e.seq   = minstret + 64'(nacc);
          exp_q.push_back(e);
          nacc++;
          if (cmt_break[l]) begin blocked = 1; brk = 1; end
        end
      end
    end
    if (mstate != 2) mcycle++;
    if (mstate == 0) begin
      if (brk) begin
        mstate = 1;
        ma0 = a0_value;
      end else if (nacc == 0 && midle == TO - 1) begin
        mstate = 2;
        mcode = 2'd3;
      end else begin
        midle = (nacc != 0) ? 0 : midle + 1;
      end
    end else if (mstate == 1 && exp_q.size() == 0) begin
      mstate = 2;
      mcode = (ma0 == 0) ? 2'd1 : 2'd2;
    end
    minstret += 64'(nacc);
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();
    chk_reset();

    // two lanes, then lane 1 only
    trace_ready = 1'b1;
    drive(2'b11, 2'b00, 64'h8000_0000, 64'h8000_0004);
    step();
    drive(2'b00, 2'b00, 64'd0, 64'd0);
    repeat (2) step();
    chk("instret_two", instret_cnt, 2);
    drive(2'b10, 2'b00, 64'd0, 64'h8000_0010);
    step();
    drive(2'b00, 2'b00, 64'd0, 64'd0);
    repeat (2) step();
    chk("instret_three", instret_cnt, 3);

    // offset pointers by two, fill to full, hold, then drain across the wrap
    do_reset();
    trace_ready = 1'b1;
    drive(2'b11, 2'b00, 64'h100, 64'h104);
    step();
    drive(2'b00, 2'b00, 64'd0, 64'd0);
    repeat (2) step();
    trace_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(2'b11, 2'b00, 64'h200 + 64'(8*k), 64'h204 + 64'(8*k));
      step();
    end
    chk("stall_full", cmt_stall, 1);
    drive(2'b11, 2'b00, 64'h900, 64'h904);
    repeat (2) step();
    drive(2'b00, 2'b00, 64'd0, 64'd0);
    trace_ready = 1'b1;
    repeat (18) step();
    chk("drained", trace_valid, 0);

    // break with a0 == 0: lane 1 dropped, good trap
    do_reset();
    trace_ready = 1'b1;
    drive(2'b11, 2'b01, 64'h300, 64'h304);
    step();
    drive(2'b00, 2'b00, 64'd0, 64'd0);
    repeat (3) step();
    chk("good_halt", halt, 1);
    chk("good_code", halt_code, 1);
    chk("good_instret", instret_cnt, 1);

    // break with a0 == 5: bad trap
    do_reset();
    trace_ready = 1'b1;
    a0_value = 64'd5;
    drive(2'b11, 2'b01, 64'h310, 64'h314);
    step();
    drive(2'b00, 2'b00, 64'd0, 64'd0);
    a0_value = 64'd0;
    repeat (3) step();
    chk("bad_halt", halt, 1);
    chk("bad_code", halt_code, 2);
    chk("bad_a0", halt_a0, 5);

    // reset while five entries are queued and halt is pending
    do_reset();
    drive(2'b11, 2'b00, 64'h400, 64'h404);
    step();
    drive(2'b11, 2'b00, 64'h408, 64'h40c);
    step();
    drive(2'b01, 2'b01, 64'h410, 64'd0);
    step();
    drive(2'b00, 2'b00, 64'd0, 64'd0);
    step();
    chk("pend_stall", cmt_stall, 1);
    chk("pend_valid", trace_valid, 1);
    do_reset();
    chk_reset();

    // no commits at all: timeout
    repeat (20) step();
    chk("to_halt", halt, 1);
    chk("to_code", halt_code, 3);
    chk("to_cycle", cycle_cnt, 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule
